// File: rtl/hdc_pkg.sv
// Shared HDC encoder definitions: default dimensions, shift-width helper and
// the binder FSM state encoding.
package hdc_pkg;

    localparam int HV_DIM_DEF          = 1024;
    localparam int FEATURES_PER_CC_DEF = 64;
    localparam int LANES_DEF           = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BIND = 2'd1,
        ST_DONE = 2'd2
    } enc_state_e;

    function automatic int shift_w(input int hv_dim);
        return (hv_dim > 1) ? $clog2(hv_dim) : 1;
    endfunction

endpackage

// File: rtl/enc_rotator.sv
// Combinational cyclic rotator: log2 stages, each rotating by a power of two
// when the matching shift bit is set, so no barrel-shifter wrap slicing is needed.
module enc_rotator
    import hdc_pkg::*;
#(
    parameter  int HV_DIM  = HV_DIM_DEF,
    parameter  int ROT_DIR = 0,
    localparam int SHIFT_W = shift_w(HV_DIM)
) (
    input  logic [HV_DIM-1:0]  level_hv,
    input  logic [SHIFT_W-1:0] shift_amt,
    output logic [HV_DIM-1:0]  rotated_hv
);

    logic [HV_DIM-1:0] w_stage;

    // Staged rotation; left moves bit j to j+s, right moves bit j+s to j
    always_comb begin
        w_stage = level_hv;
        for (int i = 0; i < SHIFT_W; i++) begin
            if (ROT_DIR == 0) begin
                w_stage = shift_amt[i] ? ((w_stage << (1 << i)) | (w_stage >> (HV_DIM - (1 << i))))
                                       : w_stage;
            end else begin
                w_stage = shift_amt[i] ? ((w_stage >> (1 << i)) | (w_stage << (HV_DIM - (1 << i))))
                                       : w_stage;
            end
        end
        rotated_hv = w_stage;
    end

endmodule

// File: rtl/enc_binder_array.sv
// Binds FEATURES level hypervectors by rotation, LANES features per cycle,
// into a registered result bank with start/busy/done/out_valid handshake.
module enc_binder_array
    import hdc_pkg::*;
#(
    parameter  int HV_DIM   = HV_DIM_DEF,
    parameter  int FEATURES = FEATURES_PER_CC_DEF,
    parameter  int LANES    = LANES_DEF,
    parameter  int ROT_DIR  = 0,
    localparam int SHIFT_W  = shift_w(HV_DIM)
) (
    input  logic                              clk,
    input  logic                              nrst,
    input  logic                              start_encoding,
    input  logic                              en,
    input  logic [FEATURES-1:0][HV_DIM-1:0]   level_hv,
    input  logic [FEATURES-1:0][SHIFT_W-1:0]  shift_amt,
    output logic [FEATURES-1:0][HV_DIM-1:0]   shifted_hv,
    output logic                              busy,
    output logic                              done,
    output logic                              out_valid
);

    localparam int GROUPS = (FEATURES + LANES - 1) / LANES;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    enc_state_e                        r_state;
    enc_state_e                        w_state_nxt;
    logic                              w_capture;
    logic                              w_write;
    logic                              w_finish;
    logic [GW-1:0]                     r_group;
    logic [FEATURES-1:0][HV_DIM-1:0]   r_level;
    logic [FEATURES-1:0][SHIFT_W-1:0]  r_shift;
    logic [FEATURES-1:0][HV_DIM-1:0]   r_shifted;
    logic                              r_busy;
    logic                              r_done;
    logic                              r_valid;
    logic [FEATURES-1:0]               w_sel;
    logic [LANES-1:0][HV_DIM-1:0]      w_lane_in;
    logic [LANES-1:0][SHIFT_W-1:0]     w_lane_sh;
    logic [LANES-1:0][HV_DIM-1:0]      w_lane_out;

    // Next-state and one-cycle control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_write     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_encoding && en) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_BIND;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BIND: begin
                if (en) begin
                    w_write = 1'b1;
                    if (r_group == GW'(GROUPS - 1)) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_BIND;
                    end
                end else begin
                    w_state_nxt = ST_BIND;
                end
            end
            ST_DONE: begin
                w_finish    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Group-indexed lane mux: feature f rides lane f%LANES in group f/LANES;
    // lanes with no feature in a partial group see zeros and are never stored
    always_comb begin
        w_sel     = '0;
        w_lane_in = '0;
        w_lane_sh = '0;
        for (int f = 0; f < FEATURES; f++) begin
            w_sel[f]               = (r_group == GW'(f / LANES));
            w_lane_in[f % LANES]   = w_lane_in[f % LANES] | ({HV_DIM{w_sel[f]}} & r_level[f]);
            w_lane_sh[f % LANES]   = w_lane_sh[f % LANES] | ({SHIFT_W{w_sel[f]}} & r_shift[f]);
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        enc_rotator #(
            .HV_DIM  (HV_DIM),
            .ROT_DIR (ROT_DIR)
        ) u_rot (
            .level_hv   (w_lane_in[l]),
            .shift_amt  (w_lane_sh[l]),
            .rotated_hv (w_lane_out[l])
        );
    end

    // Capture registers, group counter, result bank and status flags
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_level   <= '0;
            r_shift   <= '0;
            r_group   <= '0;
            r_shifted <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != ST_IDLE);
            r_done <= w_finish;
            if (w_capture) begin
                r_level <= level_hv;
                r_shift <= shift_amt;
                r_group <= '0;
                r_valid <= 1'b0;
            end else if (w_write) begin
                r_group <= r_group + GW'(1);
            end else if (w_finish) begin
                r_valid <= 1'b1;
            end
            for (int f = 0; f < FEATURES; f++) begin
                if (w_write && w_sel[f]) begin
                    r_shifted[f] <= w_lane_out[f % LANES];
                end
            end
        end
    end

    assign shifted_hv = r_shifted;
    assign busy       = r_busy;
    assign done       = r_done;
    assign out_valid  = r_valid;

endmodule

// File: tb/tb_enc_binder_array.sv
// Bench for enc_binder_array: one left- and one right-rotating instance driven
// in parallel and compared against an arithmetic rotation model.
module tb_enc_binder_array;

    localparam int HV = 16;
    localparam int NF = 5;
    localparam int NL = 2;
    localparam int NG = 3;
    localparam int SW = 4;

    logic                   clk = 1'b0;
    logic                   nrst;
    logic                   start_encoding;
    logic                   en;
    logic [NF-1:0][HV-1:0]  lvl_in;
    logic [NF-1:0][SW-1:0]  sh_in;
    logic [NF-1:0][HV-1:0]  shv     [2];
    logic                   busy_o  [2];
    logic                   done_o  [2];
    logic                   ov_o    [2];

    always #5 clk = ~clk;

    enc_binder_array #(.HV_DIM(HV), .FEATURES(NF), .LANES(NL), .ROT_DIR(0)) u_dut_l (
        .clk(clk), .nrst(nrst), .start_encoding(start_encoding), .en(en),
        .level_hv(lvl_in), .shift_amt(sh_in), .shifted_hv(shv[0]),
        .busy(busy_o[0]), .done(done_o[0]), .out_valid(ov_o[0]));

    enc_binder_array #(.HV_DIM(HV), .FEATURES(NF), .LANES(NL), .ROT_DIR(1)) u_dut_r (
        .clk(clk), .nrst(nrst), .start_encoding(start_encoding), .en(en),
        .level_hv(lvl_in), .shift_amt(sh_in), .shifted_hv(shv[1]),
        .busy(busy_o[1]), .done(done_o[1]), .out_valid(ov_o[1]));

    int n_chk  = 0;
    int n_fail = 0;

    logic [HV-1:0] exp_fin [2][NF];
    logic [HV-1:0] cur     [2][NF];
    logic [HV-1:0] saved   [NF];
    bit            exp_ov;

    int obs_done_cyc [2];
    int obs_pulses   [2];
    int obs_busy     [2];
    int obs_err      [2];
    logic obs_busy0  [2];
    logic obs_ov0    [2];

    function automatic logic [HV-1:0] rot_ref(input logic [HV-1:0] v, input int s, input int dir);
        logic [HV-1:0] r;
        r = '0;
        for (int j = 0; j < HV; j++) begin
            if (dir == 0) r[(j + s) % HV] = v[j];
            else          r[j] = v[(j + s) % HV];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_inputs();
        for (int f = 0; f < NF; f++) begin
            lvl_in[f] = 16'($urandom);
            sh_in[f]  = 4'($urandom);
        end
    endtask

    // Starts a pass with the current inputs, tracks the expected output bank
    // group by group, and records what each instance did.
    task automatic run_pass(input int stall_at, input int stall_len, input bit meddle, input bit b2b);
        int  g;
        bit  fin;
        int  fin_k;
        for (int f = 0; f < NF; f++) begin
            for (int d = 0; d < 2; d++) exp_fin[d][f] = rot_ref(lvl_in[f], int'(sh_in[f]), d);
        end
        start_encoding = 1'b1;
        en             = 1'b1;
        tick();
        start_encoding = 1'b0;
        exp_ov = 1'b0;
        g      = 0;
        fin    = 1'b0;
        fin_k  = 0;
        for (int d = 0; d < 2; d++) begin
            obs_busy0[d]    = busy_o[d];
            obs_ov0[d]      = ov_o[d];
            obs_busy[d]     = (busy_o[d] === 1'b1) ? 1 : 0;
            obs_done_cyc[d] = -1;
            obs_pulses[d]   = (done_o[d] === 1'b1) ? 1 : 0;
            obs_err[d]      = 0;
        end
        for (int k = 1; k <= 40; k++) begin
            en = !((k - 1) >= stall_at && (k - 1) < stall_at + stall_len);
            if (meddle && k == 2) begin
                randomize_inputs();
                start_encoding = 1'b1;
            end else begin
                start_encoding = 1'b0;
            end
            tick();
            if (!fin) begin
                if (g < NG) begin
                    if (en) begin
                        for (int f = 0; f < NF; f++)
                            if (f / NL == g)
                                for (int d = 0; d < 2; d++) cur[d][f] = exp_fin[d][f];
                        g++;
                    end
                end else begin
                    fin    = 1'b1;
                    fin_k  = k;
                    exp_ov = 1'b1;
                end
            end
            for (int d = 0; d < 2; d++) begin
                if (busy_o[d] === 1'b1) obs_busy[d]++;
                if (done_o[d] === 1'b1) begin
                    obs_pulses[d]++;
                    if (obs_done_cyc[d] < 0) obs_done_cyc[d] = k;
                end
                for (int f = 0; f < NF; f++) if (shv[d][f] !== cur[d][f]) obs_err[d]++;
                if (ov_o[d] !== exp_ov) obs_err[d]++;
            end
            if (fin && b2b) break;
            if (fin && k >= fin_k + 2) break;
        end
        start_encoding = 1'b0;
        en             = 1'b1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        start_encoding = 1'b0;
        en = 1'b0;
        lvl_in = '0;
        sh_in = '0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (busy_o[d] !== 1'b0 || done_o[d] !== 1'b0 || ov_o[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_flags dut%0d busy=%b done=%b ov=%b expected 0 0 0", d, busy_o[d], done_o[d], ov_o[d]);
            end
            n_chk++;
            if (shv[d] !== '0) begin
                n_fail++;
                $display("FAIL reset_hv dut%0d got=%h expected 0", d, shv[d]);
            end
            for (int f = 0; f < NF; f++) cur[d][f] = '0;
        end
        nrst = 1'b1;
        en   = 1'b1;
    endtask

    task automatic test_basic();
        randomize_inputs();
        lvl_in[0] = 16'h0001;
        sh_in[0]  = 4'd3;
        run_pass(-1, 0, 1'b0, 1'b0);
        n_chk++;
        if (shv[0][0] !== 16'h0008) begin
            n_fail++;
            $display("FAIL basic_f0 got=%h expected 0008", shv[0][0]);
        end
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (obs_busy0[d] !== 1'b1 || obs_ov0[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_accept dut%0d busy=%b ov=%b expected 1 0", d, obs_busy0[d], obs_ov0[d]);
            end
            n_chk++;
            if (obs_done_cyc[d] !== NG + 1 || obs_pulses[d] !== 1) begin
                n_fail++;
                $display("FAIL basic_done dut%0d cycle=%0d pulses=%0d expected %0d 1", d, obs_done_cyc[d], obs_pulses[d], NG + 1);
            end
            n_chk++;
            if (obs_busy[d] !== NG + 1) begin
                n_fail++;
                $display("FAIL basic_busy dut%0d cycles=%0d expected %0d", d, obs_busy[d], NG + 1);
            end
            n_chk++;
            if (obs_err[d] !== 0) begin
                n_fail++;
                $display("FAIL basic_track dut%0d errors=%0d expected 0", d, obs_err[d]);
            end
        end
    endtask

    task automatic test_zero_shift();
        randomize_inputs();
        sh_in = '0;
        for (int f = 0; f < NF; f++) saved[f] = lvl_in[f];
        run_pass(-1, 0, 1'b0, 1'b0);
        for (int d = 0; d < 2; d++) begin
            for (int f = 0; f < NF; f++) begin
                n_chk++;
                if (shv[d][f] !== saved[f]) begin
                    n_fail++;
                    $display("FAIL zero_shift dut%0d f%0d got=%h expected %h", d, f, shv[d][f], saved[f]);
                end
            end
            n_chk++;
            if (obs_err[d] !== 0 || ov_o[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL zero_shift_track dut%0d errors=%0d ov=%b expected 0 1", d, obs_err[d], ov_o[d]);
            end
        end
    endtask

    task automatic test_stall();
        randomize_inputs();
        run_pass(1, 2, 1'b0, 1'b0);
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (obs_done_cyc[d] !== NG + 3 || obs_busy[d] !== NG + 3) begin
                n_fail++;
                $display("FAIL stall_timing dut%0d done=%0d busy=%0d expected %0d %0d", d, obs_done_cyc[d], obs_busy[d], NG + 3, NG + 3);
            end
            n_chk++;
            if (obs_err[d] !== 0) begin
                n_fail++;
                $display("FAIL stall_track dut%0d errors=%0d expected 0", d, obs_err[d]);
            end
        end
    endtask

    task automatic test_busy_start();
        randomize_inputs();
        run_pass(-1, 0, 1'b1, 1'b0);
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (obs_pulses[d] !== 1 || obs_done_cyc[d] !== NG + 1) begin
                n_fail++;
                $display("FAIL busy_start dut%0d pulses=%0d done=%0d expected 1 %0d", d, obs_pulses[d], obs_done_cyc[d], NG + 1);
            end
            n_chk++;
            if (obs_err[d] !== 0) begin
                n_fail++;
                $display("FAIL busy_start_track dut%0d errors=%0d expected 0", d, obs_err[d]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        int busies;
        randomize_inputs();
        start_encoding = 1'b1;
        en = 1'b1;
        tick();
        start_encoding = 1'b0;
        tick();
        #2;
        nrst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (busy_o[d] !== 1'b0 || done_o[d] !== 1'b0 || ov_o[d] !== 1'b0 || shv[d] !== '0) begin
                n_fail++;
                $display("FAIL reset_mid dut%0d busy=%b done=%b ov=%b hv=%h expected all 0", d, busy_o[d], done_o[d], ov_o[d], shv[d]);
            end
            for (int f = 0; f < NF; f++) cur[d][f] = '0;
        end
        @(negedge clk);
        nrst = 1'b1;
        pulses = 0;
        busies = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                if (done_o[d] !== 1'b0) pulses++;
                if (busy_o[d] !== 1'b0) busies++;
            end
        end
        n_chk++;
        if (pulses !== 0 || busies !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet done_cycles=%0d busy_cycles=%0d expected 0 0", pulses, busies);
        end
        randomize_inputs();
        run_pass(-1, 0, 1'b0, 1'b0);
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (obs_done_cyc[d] !== NG + 1 || obs_err[d] !== 0) begin
                n_fail++;
                $display("FAIL reset_mid_fresh dut%0d done=%0d errors=%0d expected %0d 0", d, obs_done_cyc[d], obs_err[d], NG + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        randomize_inputs();
        lvl_in[0] = 16'h8000;
        sh_in[0]  = 4'd15;
        run_pass(-1, 0, 1'b0, 1'b1);
        n_chk++;
        if (shv[1][0] !== 16'h0001 || shv[0][0] !== 16'h4000) begin
            n_fail++;
            $display("FAIL b2b_rot right=%h left=%h expected 0001 4000", shv[1][0], shv[0][0]);
        end
        randomize_inputs();
        run_pass(-1, 0, 1'b0, 1'b0);
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (obs_busy0[d] !== 1'b1 || obs_done_cyc[d] !== NG + 1) begin
                n_fail++;
                $display("FAIL b2b_accept dut%0d busy=%b done=%0d expected 1 %0d", d, obs_busy0[d], obs_done_cyc[d], NG + 1);
            end
            n_chk++;
            if (obs_err[d] !== 0) begin
                n_fail++;
                $display("FAIL b2b_track dut%0d errors=%0d expected 0", d, obs_err[d]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_shift();
        test_stall();
        test_busy_start();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/enc_binder_array.md
ENC_BINDER_ARRAY -- requirements
Module: enc_binder_array

Interface
REQ-001 Parameter HV_DIM, default 1024, hypervector width in bits; SHALL be a power of two ≥ 8.
REQ-002 Parameter FEATURES, default 64, number of feature channels bound per encoding.
REQ-003 Parameter LANES, default 8, rotators operating in parallel; 1 ≤ LANES ≤ FEATURES.
REQ-004 Parameter ROT_DIR, default 0, rotation direction (0 = left/up, 1 = right/down).
REQ-005 Port clk, input, 1, single clock; all state SHALL be clocked on its rising edge.
REQ-006 Port nrst, input, 1, asynchronous active-low reset.
REQ-007 Port start_encoding, input, 1, request to begin one binding pass.
REQ-008 Port en, input, 1, enable; it gates start acceptance and stalls progress.
REQ-009 Port level_hv, input, HV_DIM x FEATURES, level hypervector per feature.
REQ-010 Port shift_amt, input, log2(HV_DIM) x FEATURES, rotation amount per feature.
REQ-011 Port shifted_hv, output, HV_DIM x FEATURES, registered bound hypervectors.
REQ-012 Port busy, output, 1, high while a pass is in progress.
REQ-013 Port done, output, 1, single-cycle pulse at pass completion.
REQ-014 Port out_valid, output, 1, shifted_hv holds a complete, current result.

Function
REQ-015 GROUPS = ceil(FEATURES/LANES); group g SHALL cover features g*LANES .. min((g+1)*LANES, FEATURES)-1.
REQ-016 The FSM SHALL have exactly the states IDLE, BIND, and DONE.
REQ-017 In IDLE, start_encoding && en SHALL capture level_hv and shift_amt into internal registers, clear out_valid, zero the group counter, and move to BIND.
REQ-018 In BIND with en=1, each cycle SHALL write the rotated results of the current group into shifted_hv and increment the group counter; other features' outputs SHALL hold.
REQ-019 In BIND with en=0, the group counter and all outputs SHALL hold (stall), and busy SHALL remain 1.
REQ-020 After the group GROUPS-1 write, the FSM SHALL enter DONE; DONE SHALL assert done for one cycle, set out_valid, and return to IDLE.
REQ-021 ROT_DIR=0: shifted_hv[f][(j+s) mod HV_DIM] = level_hv[f][j]; ROT_DIR=1: shifted_hv[f][j] = level_hv[f][(j+s) mod HV_DIM], with s = captured shift_amt[f].
REQ-022 Latency: with en held high and start accepted at edge 0, done SHALL be high during the cycle after edge GROUPS+1; each en=0 cycle in BIND adds one cycle.
REQ-023 busy SHALL be 1 in BIND and DONE, and 0 in IDLE.
REQ-024 start_encoding SHALL be ignored while busy; changes to level_hv or shift_amt after capture SHALL NOT affect the pass.
REQ-025 Lanes in the last partial group that have no feature SHALL write nothing.
REQ-026 shift_amt = 0 SHALL pass level_hv through unchanged.
REQ-027 Back-to-back: a start presented in the cycle after DONE SHALL be accepted.
REQ-028 out_valid and shifted_hv SHALL hold after DONE until the next accepted start.

Reset
REQ-029 nrst=0 SHALL asynchronously force the FSM to IDLE, the group counter to 0, and busy, done, and out_valid to 0.
REQ-030 nrst=0 SHALL asynchronously force shifted_hv and all capture registers to 0.
REQ-031 Reset asserted mid-pass SHALL abandon the pass; no done pulse SHALL follow deassertion.

Structure
REQ-032 HV_DIM, FEATURES_PER_CC defaults, the SHIFT_W width function, and the FSM state enum SHALL live in the shared hdc package.
REQ-033 The rotation SHALL be one combinational sub-module, enc_rotator (parameters HV_DIM and ROT_DIR), instantiated LANES times and fed through a group-indexed mux.

Verification
(parameters HV_DIM=16, FEATURES=5, LANES=2, so GROUPS=3)
REQ-034 Feature 0 level=16'h0001, shift=3, ROT_DIR=0, en=1 -> shifted_hv[0]=16'h0008; done high exactly 4 cycles after the start edge; busy high for 4 cycles.
REQ-035 All shifts=0 with random levels -> shifted_hv equals the captured levels; last-group feature 4 correct; no write beyond feature 4.
REQ-036 en dropped for 2 cycles during group 1 -> done delayed by exactly 2 cycles; results match the scoreboard.
REQ-037 level_hv changed and a second start pulsed while busy -> results reflect the captured values; only one done pulse.
REQ-038 nrst asserted during group 1 -> all outputs 0 immediately; no done pulse; a fresh start then completes normally.
REQ-039 ROT_DIR=1, level=16'h8000, shift=15 -> shifted_hv=16'h0001; back-to-back start accepted in the cycle after done.
